// File: rtl/des_cipher_uart_rx.sv
// DES ciphertext RS232 receiver: 8N1 UART deserialiser plus 64-bit word
// assembler (least-significant byte first) with framing and inter-byte
// timeout reporting so the downstream checker can discard corrupted words.
module des_cipher_uart_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int FRAME_TIMEOUT  = 20000,
  parameter int BYTES_PER_WORD = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX,
  output logic [7:0]                  BYTE_DATA,
  output logic                        BYTE_VALID,
  output logic [8*BYTES_PER_WORD-1:0] WORD_DATA,
  output logic                        WORD_VALID,
  output logic [2:0]                  BYTE_IDX,
  output logic                        FRAMING_ERR,
  output logic                        TIMEOUT_ERR
);

  localparam int WW = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_END   = TW'(FRAME_TIMEOUT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(BYTES_PER_WORD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rxMeta;
  logic          rxS;
  logic          rxPrev;
  logic [1:0]    state;
  logic [CW-1:0] clkCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic [WW-1:0] partial;
  logic [WW-1:0] fullWord;
  logic [TW-1:0] toCnt;
  logic          stopTick;
  logic          byteOk;
  logic          frameBad;

  assign stopTick = (state == STOP) && (clkCnt == BIT_END);
  assign byteOk   = stopTick && rxS;
  assign frameBad = stopTick && !rxS;

  // Partial word with the byte currently leaving the stop bit dropped into its slot.
  always_comb begin
    fullWord = partial;
    fullWord[{BYTE_IDX, 3'b000} +: 8] = shiftReg;
  end

  // Two-flop synchroniser on RX plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= RX;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  // Bit-level FSM: find the start bit, mid-bit sample 8 data bits LSB first, check stop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      clkCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          clkCnt <= '0;
          bitIdx <= '0;
          // A line held low after a bad stop bit does not count; only a fresh edge does.
          if (rxPrev && !rxS) state <= START;
        end
        START: begin
          if (clkCnt == HALF_END) begin
            clkCnt <= '0;
            state  <= rxS ? IDLE : DATA;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        DATA: begin
          if (clkCnt == BIT_END) begin
            clkCnt   <= '0;
            shiftReg <= {rxS, shiftReg[7:1]};
            bitIdx   <= bitIdx + 1'b1;
            if (bitIdx == 3'd7) state <= STOP;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        default: begin
          if (clkCnt == BIT_END) begin
            clkCnt <= '0;
            state  <= IDLE;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Word assembly, error pulses and inter-byte timeout; an accepted byte beats a timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BYTE_DATA   <= '0;
      BYTE_VALID  <= 1'b0;
      WORD_DATA   <= '0;
      WORD_VALID  <= 1'b0;
      BYTE_IDX    <= '0;
      FRAMING_ERR <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      partial     <= '0;
      toCnt       <= '0;
    end else begin
      BYTE_VALID  <= 1'b0;
      WORD_VALID  <= 1'b0;
      FRAMING_ERR <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      if (byteOk) begin
        BYTE_DATA  <= shiftReg;
        BYTE_VALID <= 1'b1;
        toCnt      <= '0;
        if (BYTE_IDX == LAST_IDX) begin
          WORD_DATA  <= fullWord;
          WORD_VALID <= 1'b1;
          BYTE_IDX   <= '0;
          partial    <= '0;
        end else begin
          partial  <= fullWord;
          BYTE_IDX <= BYTE_IDX + 1'b1;
        end
      end else if (frameBad) begin
        FRAMING_ERR <= 1'b1;
        BYTE_IDX    <= '0;
        partial     <= '0;
        toCnt       <= '0;
      end else if (BYTE_IDX == 3'd0) begin
        toCnt <= '0;
      end else if (toCnt == TO_END) begin
        TIMEOUT_ERR <= 1'b1;
        BYTE_IDX    <= '0;
        partial     <= '0;
        toCnt       <= '0;
      end else begin
        toCnt <= toCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_des_cipher_uart_rx.sv
// Bench for des_cipher_uart_rx: a UART line driver, an output monitor and
// per-scenario tasks comparing against words packed from the bytes sent.
module tb_des_cipher_uart_rx;

  localparam int CPB = 16;
  localparam int TO  = 2000;
  localparam int LAT_NOM = (19 * CPB) / 2 + 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX  = 1'b1;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_VALID;
  logic [63:0] WORD_DATA;
  logic        WORD_VALID;
  logic [2:0]  BYTE_IDX;
  logic        FRAMING_ERR;
  logic        TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int startCyc = -1;
  int lastByteCyc = 0;
  int lastLat = 0;
  int toCyc = 0;
  int ferrCnt = 0;
  int terrCnt = 0;
  int wordAlignErr = 0;
  logic [7:0]  byteQ[$];
  logic [63:0] wordQ[$];

  des_cipher_uart_rx #(.CLKS_PER_BIT(CPB), .FRAME_TIMEOUT(TO), .BYTES_PER_WORD(8)) dut (
    .CLK(CLK), .RST(RST), .RX(RX),
    .BYTE_DATA(BYTE_DATA), .BYTE_VALID(BYTE_VALID),
    .WORD_DATA(WORD_DATA), .WORD_VALID(WORD_VALID),
    .BYTE_IDX(BYTE_IDX), .FRAMING_ERR(FRAMING_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (BYTE_VALID) begin
      byteQ.push_back(BYTE_DATA);
      lastByteCyc = cyc;
      lastLat = cyc - startCyc;
    end
    if (WORD_VALID) begin
      wordQ.push_back(WORD_DATA);
      if (!BYTE_VALID) wordAlignErr++;
    end
    if (FRAMING_ERR) ferrCnt++;
    if (TIMEOUT_ERR) begin
      terrCnt++;
      toCyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stopBit);
    @(negedge CLK);
    RX = 1'b0;
    startCyc = cyc;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = stopBit;
    repeat (CPB) @(negedge CLK);
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_word(input logic [63:0] w, input int gapMax);
    for (int k = 0; k < 8; k++) begin
      send_byte(w[8*k +: 8], 1'b1);
      idle($urandom_range(0, gapMax));
    end
  endtask

  task automatic clear_mon();
    byteQ.delete();
    wordQ.delete();
    ferrCnt = 0;
    terrCnt = 0;
    wordAlignErr = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    RX = 1'b1;
    idle(3);
    RST = 1'b0;
    idle(3);
    clear_mon();
  endtask

  task automatic check_word(input string name, input logic [63:0] exp);
    checks++;
    if (wordQ.size() != 1) begin
      errors++;
      $display("FAIL %s word count got %0d exp 1", name, wordQ.size());
    end else if (wordQ[0] !== exp) begin
      errors++;
      $display("FAIL %s word got %h exp %h", name, wordQ[0], exp);
    end
    checks++;
    if (BYTE_IDX !== 3'd0 || wordAlignErr != 0) begin
      errors++;
      $display("FAIL %s idx/align got idx %0d align %0d exp 0 0", name, BYTE_IDX, wordAlignErr);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(4);
    checks++;
    if ({BYTE_DATA, BYTE_VALID, WORD_DATA, WORD_VALID, BYTE_IDX, FRAMING_ERR, TIMEOUT_ERR} !== '0) begin
      errors++;
      $display("FAIL reset_state got bd %h wd %h idx %0d exp all zero", BYTE_DATA, WORD_DATA, BYTE_IDX);
    end
    RST = 1'b0;
    idle(4);
  endtask

  task automatic test_single_byte();
    do_reset();
    send_byte(8'h55, 1'b1);
    idle(10);
    checks++;
    if (byteQ.size() != 1 || byteQ[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_byte got n=%0d b=%h exp n=1 b=55", byteQ.size(), (byteQ.size() > 0) ? byteQ[0] : 8'hxx);
    end
    checks++;
    if (BYTE_IDX !== 3'd1 || wordQ.size() != 0) begin
      errors++;
      $display("FAIL single_idx got idx %0d words %0d exp 1 0", BYTE_IDX, wordQ.size());
    end
    checks++;
    if (lastLat < LAT_NOM - 6 || lastLat > LAT_NOM + 6) begin
      errors++;
      $display("FAIL byte_latency got %0d exp about %0d", lastLat, LAT_NOM);
    end
  endtask

  task automatic test_word();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      send_byte(8'(k), 1'b1);
      idle(CPB * 6);
    end
    check_word("word_0807", 64'h0807060504030201);
  endtask

  task automatic test_glitch();
    do_reset();
    RX = 1'b0;
    idle(CPB / 4);
    RX = 1'b1;
    idle(CPB * 12);
    checks++;
    if (byteQ.size() != 0 || ferrCnt != 0) begin
      errors++;
      $display("FAIL glitch got bytes %0d ferr %0d exp 0 0", byteQ.size(), ferrCnt);
    end
    send_byte(8'hA3, 1'b1);
    idle(10);
    checks++;
    if (byteQ.size() != 1 || byteQ[0] !== 8'hA3) begin
      errors++;
      $display("FAIL glitch_after got n=%0d exp A3", byteQ.size());
    end
  endtask

  task automatic test_framing();
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
    idle(5);
    checks++;
    if (BYTE_IDX !== 3'd3) begin
      errors++;
      $display("FAIL pre_frame_idx got %0d exp 3", BYTE_IDX);
    end
    send_byte(8'hFF, 1'b0);
    idle(CPB * 2);
    checks++;
    if (ferrCnt != 1 || BYTE_IDX !== 3'd0 || byteQ.size() != 3 || terrCnt != 0) begin
      errors++;
      $display("FAIL framing got ferr %0d idx %0d bytes %0d exp 1 0 3", ferrCnt, BYTE_IDX, byteQ.size());
    end
    send_word(64'h1716151413121110, CPB * 3);
    check_word("frame_word", 64'h1716151413121110);
  endtask

  task automatic test_timeout();
    int waited;
    logic [63:0] w;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'($urandom), 1'b1);
      idle($urandom_range(0, CPB * 3));
    end
    waited = 0;
    while (terrCnt == 0 && waited < TO + 500) begin
      @(negedge CLK);
      waited++;
    end
    checks++;
    if (terrCnt != 1) begin
      errors++;
      $display("FAIL timeout_pulse got %0d exp 1", terrCnt);
    end else begin
      checks++;
      if (toCyc - lastByteCyc != TO) begin
        errors++;
        $display("FAIL timeout_delay got %0d exp %0d", toCyc - lastByteCyc, TO);
      end
    end
    checks++;
    if (BYTE_IDX !== 3'd0 || ferrCnt != 0) begin
      errors++;
      $display("FAIL timeout_idx got idx %0d ferr %0d exp 0 0", BYTE_IDX, ferrCnt);
    end
    w = {$urandom, $urandom};
    send_word(w, CPB * 3);
    check_word("timeout_word", w);
  endtask

  task automatic test_reset_midword();
    int nBefore;
    do_reset();
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1);
    nBefore = byteQ.size();
    fork
      send_byte(8'h5A, 1'b1);
      begin
        @(negedge CLK);
        idle(4 * CPB + CPB / 2);
        RST = 1'b1;
        #1;
        checks++;
        if ({BYTE_DATA, BYTE_VALID, WORD_DATA, WORD_VALID, BYTE_IDX, FRAMING_ERR, TIMEOUT_ERR} !== '0) begin
          errors++;
          $display("FAIL midreset_clear got bd %h idx %0d exp zero", BYTE_DATA, BYTE_IDX);
        end
      end
    join
    idle(5);
    RST = 1'b0;
    idle(5);
    checks++;
    if (byteQ.size() != nBefore || wordQ.size() != 0 || ferrCnt != 0 || terrCnt != 0) begin
      errors++;
      $display("FAIL midreset_pulses got bytes %0d exp %0d", byteQ.size(), nBefore);
    end
    clear_mon();
    send_word(64'hDEADBEEFCAFEF00D, CPB * 3);
    check_word("reset_word", 64'hDEADBEEFCAFEF00D);
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    logic [7:0]  expBytes[$];
    do_reset();
    for (int n = 0; n < 3; n++) begin
      w = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) expBytes.push_back(w[8*k +: 8]);
      wordQ.delete();
      wordAlignErr = 0;
      send_word(w, (n == 0) ? 0 : CPB * 2);
      idle(2);
      check_word("b2b_word", w);
    end
    checks++;
    if (byteQ.size() != expBytes.size() || byteQ != expBytes) begin
      errors++;
      $display("FAIL b2b_bytes got n=%0d exp n=%0d", byteQ.size(), expBytes.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_word();
    test_glitch();
    test_framing();
    test_timeout();
    test_reset_midword();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
